// File: rtl/cmp_resp_64.sv
// cmp_resp_64: valid/ready request wrapper around an external fixed-latency
// 64-bit comparator. Tracks in-flight requests with a valid/tag shift chain,
// decodes the returned code into flags, and buffers results in a FIFO whose
// occupancy is bounded by a credit counter.
module cmp_resp_64 #(
    parameter int unsigned LAT   = 7,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [63:0]      cmp_a,
    output logic [63:0]      cmp_b,
    input  logic [63:0]      cmp_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_eq,
    output logic             out_gt,
    output logic             out_lt,
    output logic             out_bad,
    output logic             err_sticky
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             eq;
        logic             gt;
        logic             lt;
        logic             bad;
    } res_t;

    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [LAT-1:0]   r_vld;
    logic [TAG_W-1:0] r_tag [LAT];
    res_t             w_res;
    res_t             r_mem [DEPTH];
    res_t             r_head;
    res_t             w_head_nxt;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW-1:0]    w_rptr_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_remain;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    r_credits;
    logic             r_err;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign cmp_a      = in_a;
    assign cmp_b      = in_b;
    assign in_ready   = (r_credits != '0);
    assign w_accept   = in_valid && in_ready;
    assign w_push     = r_vld[LAT-1];
    assign out_valid  = (r_count != '0);
    assign w_pop      = out_valid && out_ready;
    assign out_tag    = r_head.tag;
    assign out_eq     = r_head.eq;
    assign out_gt     = r_head.gt;
    assign out_lt     = r_head.lt;
    assign out_bad    = r_head.bad;
    assign err_sticky = r_err;

    // Valid chain: one bit per comparator stage, never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[LAT-2:0], w_accept};
        end
    end

    // Tag chain: follows the valid chain; only meaningful where valid is set.
    always_ff @(posedge clk) begin
        r_tag[0] <= in_tag;
        for (int unsigned i = 1; i < LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
        end
    end

    // Decode the full 64-bit comparator code for the stage leaving the chain.
    always_comb begin
        w_res     = '0;
        w_res.tag = r_tag[LAT-1];
        if (cmp_code == 64'd0) begin
            w_res.eq = 1'b1;
        end else if (cmp_code == 64'd1) begin
            w_res.gt = 1'b1;
        end else if (cmp_code == 64'd2) begin
            w_res.lt = 1'b1;
        end else begin
            w_res.bad = 1'b1;
        end
    end

    // Credit pool: in-flight plus buffered results never exceed DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= CW'(DEPTH);
        end else if (w_accept && !w_pop) begin
            r_credits <= r_credits - CW'(1);
        end else if (!w_accept && w_pop) begin
            r_credits <= r_credits + CW'(1);
        end
    end

    // Next FIFO state; the head register is loaded with whatever entry
    // will be at the front after this edge, bypassing the pushed entry when
    // nothing older survives, and holds its value once the FIFO drains.
    always_comb begin
        w_rptr_nxt  = w_pop ? ptr_inc(r_rptr) : r_rptr;
        w_remain    = w_pop ? (r_count - CW'(1)) : r_count;
        w_count_nxt = w_push ? (w_remain + CW'(1)) : w_remain;
        w_head_nxt  = r_head;
        if (w_count_nxt != '0) begin
            if (w_remain == '0) begin
                w_head_nxt = w_res;
            end else begin
                w_head_nxt = r_mem[w_rptr_nxt];
            end
        end
    end

    // FIFO pointers, occupancy, head register and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            if (w_push && w_res.bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_res;
        end
    end

endmodule

// File: tb/tb_cmp_resp_64.sv
// Bench for cmp_resp_64: external comparator model, table of directed
// vectors, multi-cycle hand sequences and a randomized run checked against
// a queue-based reference model.
module tb_cmp_resp_64;

    localparam int LAT   = 7;
    localparam int DEPTH = 8;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic [63:0]      cmp_a;
    logic [63:0]      cmp_b;
    logic [63:0]      cmp_code;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic             out_eq;
    logic             out_gt;
    logic             out_lt;
    logic             out_bad;
    logic             err_sticky;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    cmp_resp_64 #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_code(cmp_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_eq(out_eq), .out_gt(out_gt),
        .out_lt(out_lt), .out_bad(out_bad), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Free-running comparator with optional forced code for the next capture.
    logic        cmp_force = 1'b0;
    logic [63:0] cmp_force_val = '0;
    logic [63:0] cmp_pipe [LAT];

    function automatic logic [63:0] ref_code(input logic [63:0] a, input logic [63:0] b,
                                             input logic fen, input logic [63:0] fval);
        if (fen) return fval;
        if (a == b) return 64'd0;
        return (a > b) ? 64'd1 : 64'd2;
    endfunction

    always @(posedge clk) begin
        cmp_pipe[0] <= ref_code(cmp_a, cmp_b, cmp_force, cmp_force_val);
        for (int i = 1; i < LAT; i++) cmp_pipe[i] <= cmp_pipe[i-1];
    end
    assign cmp_code = cmp_pipe[LAT-1];

    // Reference model: requests wait in a queue until their due cycle,
    // then move to an output queue; credits are simply the free room.
    typedef struct {
        int unsigned      due;
        logic [TAG_W-1:0] tag;
        logic             eq, gt, lt, bad;
    } ent_t;

    ent_t        inflight[$];
    ent_t        fifo[$];
    ent_t        m_last = '{0, 0, 0, 0, 0, 0};
    logic        m_sticky = 1'b0;
    int unsigned cyc = 0;

    always @(posedge clk) begin : model
        ent_t        e;
        bit          pop, acc, push;
        logic [63:0] code;
        if (rst) begin
            inflight.delete();
            fifo.delete();
            m_last   = '{0, 0, 0, 0, 0, 0};
            m_sticky = 1'b0;
        end else begin
            pop  = (fifo.size() != 0) && out_ready;
            acc  = in_valid && ((inflight.size() + fifo.size()) < DEPTH);
            push = (inflight.size() != 0) && (inflight[0].due == cyc);
            if (pop) m_last = fifo.pop_front();
            if (push) begin
                if (mon_en) chk("push_room", fifo.size() < DEPTH, 1);
                e = inflight.pop_front();
                fifo.push_back(e);
                if (e.bad) m_sticky = 1'b1;
            end
            if (acc) begin
                code  = ref_code(in_a, in_b, cmp_force, cmp_force_val);
                e.due = cyc + LAT;
                e.tag = in_tag;
                e.eq  = (code == 0);
                e.gt  = (code == 1);
                e.lt  = (code == 2);
                e.bad = (code > 2);
                inflight.push_back(e);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin : monitor
        ent_t e;
        if (mon_en) begin
            chk("mon_in_ready", in_ready, (inflight.size() + fifo.size()) < DEPTH);
            chk("mon_out_valid", out_valid, fifo.size() != 0);
            e = (fifo.size() != 0) ? fifo[0] : m_last;
            chk("mon_head", {out_tag, out_eq, out_gt, out_lt, out_bad}, {e.tag, e.eq, e.gt, e.lt, e.bad});
            chk("mon_err", err_sticky, m_sticky);
            chk("mon_cmp_a", cmp_a, in_a);
            chk("mon_cmp_b", cmp_b, in_b);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid at a negedge; n counts rising edges since the call.
    task automatic wait_out(input int unsigned limit, output int unsigned n, output bit ok);
        ok = 1'b0;
        n  = 0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            if (n >= limit) break;
            @(posedge clk);
            n++;
        end
    endtask

    typedef struct {
        logic [63:0]      a, b;
        logic [TAG_W-1:0] tag;
        logic             fen;
        logic [63:0]      fval;
        logic             eq, gt, lt, bad;
    } vec_t;

    vec_t vt [10];

    initial begin : stim
        int unsigned n;
        bit          ok;
        bit          rdy;
        bit          last_rdy;
        int          acc_cnt;
        logic [TAG_W-1:0] exp_tag;

        vt[0] = '{a:64'h1111_1111_1111_1111, b:64'h1111_1111_1111_1111, tag:4'd0, fen:1'b0, fval:64'd0, eq:1, gt:0, lt:0, bad:0};
        vt[1] = '{a:64'h5, b:64'h3, tag:4'd1, fen:1'b0, fval:64'd0, eq:0, gt:1, lt:0, bad:0};
        vt[2] = '{a:64'h3, b:64'h5, tag:4'd2, fen:1'b0, fval:64'd0, eq:0, gt:0, lt:1, bad:0};
        vt[3] = '{a:64'hFFFF_FFFF_FFFF_FFFF, b:64'h0, tag:4'd3, fen:1'b0, fval:64'd0, eq:0, gt:1, lt:0, bad:0};
        vt[4] = '{a:64'h0, b:64'hFFFF_FFFF_FFFF_FFFF, tag:4'd4, fen:1'b0, fval:64'd0, eq:0, gt:0, lt:1, bad:0};
        vt[5] = '{a:64'h8000_0000_0000_0000, b:64'h7FFF_FFFF_FFFF_FFFF, tag:4'd5, fen:1'b0, fval:64'd0, eq:0, gt:1, lt:0, bad:0};
        vt[6] = '{a:64'h5, b:64'h5, tag:4'd6, fen:1'b1, fval:64'h3, eq:0, gt:0, lt:0, bad:1};
        vt[7] = '{a:64'h1, b:64'h2, tag:4'd7, fen:1'b1, fval:64'h1_0000_0000, eq:0, gt:0, lt:0, bad:1};
        vt[8] = '{a:64'h9, b:64'h9, tag:4'd8, fen:1'b1, fval:64'h8000_0000_0000_0001, eq:0, gt:0, lt:0, bad:1};
        vt[9] = '{a:64'h9, b:64'h9, tag:4'd9, fen:1'b1, fval:64'h2, eq:0, gt:0, lt:1, bad:0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_fields", {out_tag, out_eq, out_gt, out_lt, out_bad}, 0);
        chk("rst_err", err_sticky, 0);
        step();

        // Single request: exact latency and equal decode.
        in_valid = 1'b1; in_a = 64'h1111_1111_1111_1111; in_b = 64'h1111_1111_1111_1111; in_tag = 4'd3;
        step();
        in_valid = 1'b0;
        wait_out(20, n, ok);
        chk("t1_seen", ok, 1);
        chk("t1_latency", n, 7);
        chk("t1_result", {out_tag, out_eq, out_gt, out_lt, out_bad}, {4'd3, 4'b1000});
        out_ready = 1'b1;
        step();

        // Back-to-back requests with out_ready held high.
        in_valid = 1'b1; in_a = 64'h5; in_b = 64'h3; in_tag = 4'd1; step();
        in_a = 64'h3; in_b = 64'h5; in_tag = 4'd2; step();
        in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h0; in_tag = 4'd3; step();
        in_valid = 1'b0;
        wait_out(20, n, ok);
        chk("t2_seen", ok, 1);
        chk("t2_r0", {out_valid, out_tag, out_eq, out_gt, out_lt, out_bad}, {1'b1, 4'd1, 4'b0100});
        @(negedge clk);
        chk("t2_r1", {out_valid, out_tag, out_eq, out_gt, out_lt, out_bad}, {1'b1, 4'd2, 4'b0010});
        @(negedge clk);
        chk("t2_r2", {out_valid, out_tag, out_eq, out_gt, out_lt, out_bad}, {1'b1, 4'd3, 4'b0100});
        step();

        // Directed vector table, one request at a time.
        for (int i = 0; i < 10; i++) begin
            in_a = vt[i].a; in_b = vt[i].b; in_tag = vt[i].tag;
            cmp_force = vt[i].fen; cmp_force_val = vt[i].fval;
            in_valid = 1'b1; out_ready = 1'b1;
            step();
            in_valid = 1'b0; cmp_force = 1'b0;
            wait_out(20, n, ok);
            chk($sformatf("vec%0d_seen", i), ok, 1);
            chk($sformatf("vec%0d_lat", i), n, 7);
            chk($sformatf("vec%0d_res", i), {out_tag, out_eq, out_gt, out_lt, out_bad},
                {vt[i].tag, vt[i].eq, vt[i].gt, vt[i].lt, vt[i].bad});
            step();
        end
        chk("sticky_after_bad", err_sticky, 1);
        repeat (3) step();
        chk("sticky_holds", err_sticky, 1);

        rst = 1'b1; step(); rst = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", err_sticky, 0);
        step();

        // Backpressure: 10 offered, 8 accepted, then drain in order.
        out_ready = 1'b0; acc_cnt = 0;
        in_valid = 1'b1; in_tag = 4'd0; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            rdy = in_ready;
            step();
            if (rdy) begin
                acc_cnt++;
                in_tag = in_tag + 4'd1;
                in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
            end
        end
        in_valid = 1'b0;
        chk("t3_accepted", acc_cnt, 8);
        chk("t3_blocked", in_ready, 0);
        repeat (10) step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_rdy_before_pop", in_ready, 0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("t3_drain%0d", k), {out_valid, out_tag}, {1'b1, 4'(k)});
            if (k == 1) chk("t3_rdy_after_pop", in_ready, 1);
        end
        @(negedge clk);
        chk("t3_empty", out_valid, 0);
        step();

        // Fill completely, then hold in_valid and out_ready high.
        out_ready = 1'b0; acc_cnt = 0; exp_tag = 4'd0;
        in_valid = 1'b1; in_tag = exp_tag; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
        for (int i = 0; i < 20 && acc_cnt < 8; i++) begin
            rdy = in_ready;
            step();
            if (rdy) begin
                acc_cnt++;
                exp_tag = exp_tag + 4'd1;
                in_tag = exp_tag; in_a = {$urandom, $urandom}; in_b = in_a ^ 64'($urandom_range(0, 1));
            end
        end
        chk("t4_filled", acc_cnt, 8);
        repeat (9) step();
        chk("t4_full_valid", out_valid, 1);
        chk("t4_full_ready", in_ready, 0);
        out_ready = 1'b1; acc_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            rdy = in_ready;
            step();
            if (rdy) begin
                acc_cnt++;
                exp_tag = exp_tag + 4'd1;
                in_tag = exp_tag; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
            end
        end
        chk("t4_throughput", acc_cnt >= 20, 1);
        in_valid = 1'b0;
        repeat (20) step();
        chk("t4_drained", out_valid, 0);

        // Reset with 3 buffered and 4 in flight.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_tag = 4'(i); in_a = 64'(i); in_b = 64'd1; step();
        end
        in_valid = 1'b0;
        repeat (8) step();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_tag = 4'(8 + i); in_a = 64'd7; in_b = 64'(i); step();
        end
        in_valid = 1'b0;
        step();
        chk("t5_pre_valid", out_valid, 1);
        rst = 1'b1; step(); rst = 1'b0;
        @(negedge clk);
        chk("t5_post_valid", out_valid, 0);
        chk("t5_post_ready", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t5_quiet%0d", i), out_valid, 0);
        end
        step();

        // Randomized traffic checked by the reference model.
        last_rdy = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1; in_valid = 1'b0; cmp_force = 1'b0;
            end else begin
                rst = 1'b0;
                if (!(in_valid && !last_rdy)) begin
                    in_valid = ($urandom_range(0, 2) != 0);
                    in_a = {$urandom, $urandom};
                    in_b = ($urandom_range(0, 3) == 0) ? in_a : {$urandom, $urandom};
                    in_tag = 4'($urandom);
                    cmp_force = ($urandom_range(0, 15) == 0);
                    cmp_force_val = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 5)) : {$urandom, $urandom};
                end
            end
            out_ready = (((c / 50) % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            last_rdy = in_ready;
            step();
        end
        rst = 1'b0; in_valid = 1'b0; cmp_force = 1'b0; out_ready = 1'b1;
        repeat (20) step();
        chk("final_empty", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
